// File: rtl/bus_arbiter.sv
// Two-master / one-slave round-robin arbiter for the Wishbone-style CPU bus.
// Optional slave-ack watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o,
  output logic        err_o
);

  if ((2 ** TO_W) <= TIMEOUT) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, RELEASE} state_t;

  state_t state, state_nx;
  // last = index of the most recent grant; it also names the owner while busy
  logic   last, last_nx;
  logic   owned, busy, own_stb, to_hit;

  assign owned   = (state == GNT0) || (state == GNT1);
  assign busy    = (state != IDLE);
  assign own_stb = last ? m1_stb_i : m0_stb_i;

`ifdef ARB_TIMEOUT_EN
  logic [TO_W-1:0] wd;

  assign to_hit = owned && (wd == TO_W'(TIMEOUT));

  // Counts only while strobing the slave without an ack; any grant change clears it.
  always_ff @(posedge clk) begin
    if (!rst_i)
      wd <= '0;
    else if (owned && (state_nx == state) && !s_ack_i)
      wd <= wd + 1'b1;
    else
      wd <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (m0_stb_i && m1_stb_i) last_nx = ~last;
        else if (m0_stb_i)        last_nx = 1'b0;
        else if (m1_stb_i)        last_nx = 1'b1;
        if (m0_stb_i || m1_stb_i) state_nx = last_nx ? GNT1 : GNT0;
      end
      GNT0, GNT1: begin
        if (to_hit)        state_nx = RELEASE;
        else if (!own_stb) state_nx = s_ack_i ? RELEASE : IDLE;
      end
      RELEASE: begin
        if (!s_ack_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  logic        ack_fwd;
  logic [31:0] dat_fwd;

  assign ack_fwd = s_ack_i || to_hit;
  assign dat_fwd = to_hit ? 32'hDEAD_BEEF : s_dat_i;

  always_comb begin
    gnt_o    = 2'b00;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = 32'h0;
    s_dat_o  = 32'h0;
    s_sel_o  = 4'h0;
    m0_ack_o = 1'b0;
    m0_dat_o = 32'h0;
    m1_ack_o = 1'b0;
    m1_dat_o = 32'h0;
    err_o    = to_hit;
    if (busy) begin
      gnt_o   = last ? 2'b10 : 2'b01;
      // RELEASE keeps the owner's qualifiers on the bus but never strobes
      s_stb_o = owned && !to_hit;
      s_we_o  = last ? m1_we_i  : m0_we_i;
      s_adr_o = last ? m1_adr_i : m0_adr_i;
      s_dat_o = last ? m1_dat_i : m0_dat_i;
      s_sel_o = last ? m1_sel_i : m0_sel_i;
      if (last) begin
        m1_ack_o = ack_fwd;
        m1_dat_o = dat_fwd;
      end else begin
        m0_ack_o = ack_fwd;
        m0_dat_o = dat_fwd;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of the arbitration rules.
module tb_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TO = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_TO = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk, rst_i;
  logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_ack_o, m1_ack_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [1:0]  gnt_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT(TB_TO), .TO_W(8)) dut (
    .clk(clk), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0; m0_sel_i = 0;
    m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0; m1_sel_i = 0;
    s_ack_i = 0; s_dat_i = 0;
  endtask

  task automatic test_reset;
    logic [143:0] outs;
    clear_inputs();
    m0_stb_i = 1; m1_stb_i = 1; m0_adr_i = 32'h55; m1_adr_i = 32'h66;
    s_ack_i = 1; s_dat_i = 32'hFFFF_FFFF;
    rst_i = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      outs = {m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o, s_stb_o, s_we_o, s_adr_o,
              s_dat_o, s_sel_o, gnt_o, err_o};
      checks++;
      if (outs !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 0", outs);
      end
    end
    rst_i = 1; s_ack_i = 0;
    step();
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant: got %b expected 01", gnt_o);
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_single_read;
    clear_inputs();
    m0_stb_i = 1; m0_adr_i = 32'h100; m0_sel_i = 4'hF;
    step();
    checks++;
    if (gnt_o !== 2'b01 || s_stb_o !== 1'b1 || s_adr_o !== 32'h100 || s_we_o !== 1'b0) begin
      errors++;
      $display("FAIL read_grant: got gnt=%b stb=%b adr=%h we=%b expected 01 1 100 0",
               gnt_o, s_stb_o, s_adr_o, s_we_o);
    end
    step(); step();
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1;
    checks++;
    if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h1234_5678 || m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL read_ack: got m0 %b/%h m1 %b/%h expected 1/12345678 0/0",
               m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o);
    end
    step();
    m0_stb_i = 0; s_ack_i = 0;
    step();
    checks++;
    if (gnt_o !== 2'b00 || s_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: got gnt=%b stb=%b expected 00 0", gnt_o, s_stb_o);
    end
  endtask

  task automatic test_contention;
    logic [1:0] exp_gnt [3];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
    clear_inputs();
    rst_i = 0; step(); rst_i = 1;
    m0_stb_i = 1; m1_stb_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt_o !== exp_gnt[i]) begin
        errors++;
        $display("FAIL contention_gnt%0d: got %b expected %b", i, gnt_o, exp_gnt[i]);
      end
      s_ack_i = 1;
      step();
      if (exp_gnt[i] == 2'b01) m0_stb_i = 0; else m1_stb_i = 0;
      s_ack_i = 0;
      step();
      checks++;
      if (gnt_o !== 2'b00) begin
        errors++;
        $display("FAIL contention_dead%0d: got %b expected 00", i, gnt_o);
      end
      m0_stb_i = 1; m1_stb_i = 1;
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_late_ack;
    clear_inputs();
    m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'h200; m1_sel_i = 4'b0011; m1_dat_i = 32'hABCD;
    step();
    checks++;
    if (gnt_o !== 2'b10 || s_stb_o !== 1 || s_we_o !== 1 || s_adr_o !== 32'h200 ||
        s_sel_o !== 4'b0011 || s_dat_o !== 32'hABCD) begin
      errors++;
      $display("FAIL late_grant: got gnt=%b stb=%b we=%b adr=%h sel=%b dat=%h",
               gnt_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o);
    end
    s_ack_i = 1; m0_stb_i = 1;
    step();
    m1_stb_i = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (gnt_o !== 2'b10 || s_stb_o !== 0 || m1_ack_o !== 1 || m0_ack_o !== 0) begin
        errors++;
        $display("FAIL late_release%0d: got gnt=%b stb=%b ack1=%b ack0=%b expected 10 0 1 0",
                 i, gnt_o, s_stb_o, m1_ack_o, m0_ack_o);
      end
    end
    s_ack_i = 0;
    step();
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL late_idle: got %b expected 00", gnt_o);
    end
    step();
    checks++;
    if (gnt_o !== 2'b01) begin
      errors++;
      $display("FAIL late_m0_gnt: got %b expected 01", gnt_o);
    end
    clear_inputs();
    step();
    step();
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    m1_stb_i = 1; m1_adr_i = 32'h300;
    step();
    checks++;
    if (gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL midrst_grant: got %b expected 10", gnt_o);
    end
    step();
    rst_i = 0; s_ack_i = 1;
    step();
    checks++;
    if (s_stb_o !== 0 || gnt_o !== 2'b00 || m1_ack_o !== 0) begin
      errors++;
      $display("FAIL midrst_drop: got stb=%b gnt=%b ack1=%b expected 0 00 0", s_stb_o, gnt_o, m1_ack_o);
    end
    rst_i = 1;
    clear_inputs();
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    clear_inputs();
    m0_stb_i = 1; m0_adr_i = 32'h400;
    step();
    for (int i = 0; i < TB_TO; i++) begin
      checks++;
      if (s_stb_o !== 1 || m0_ack_o !== 0 || err_o !== 0) begin
        errors++;
        $display("FAIL timeout_wait%0d: got stb=%b ack=%b err=%b expected 1 0 0", i, s_stb_o, m0_ack_o, err_o);
      end
      step();
    end
    checks++;
    if (m0_ack_o !== 1 || m0_dat_o !== 32'hDEADBEEF || err_o !== 1 || s_stb_o !== 0) begin
      errors++;
      $display("FAIL timeout_fire: got ack=%b dat=%h err=%b stb=%b expected 1 deadbeef 1 0",
               m0_ack_o, m0_dat_o, err_o, s_stb_o);
    end
    m0_stb_i = 0;
    step();
    checks++;
    if (err_o !== 0 || m0_ack_o !== 0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b ack=%b expected 0 0", err_o, m0_ack_o);
    end
    step();
    checks++;
    if (gnt_o !== 2'b00) begin
      errors++;
      $display("FAIL timeout_idle: got %b expected 00", gnt_o);
    end
  endtask
`else
  task automatic test_hang;
    clear_inputs();
    m0_stb_i = 1;
    step();
    for (int i = 0; i < 300; i++) step();
    checks++;
    if (gnt_o !== 2'b01 || s_stb_o !== 1 || err_o !== 0 || m0_ack_o !== 0) begin
      errors++;
      $display("FAIL hang_hold: got gnt=%b stb=%b err=%b ack=%b expected 01 1 0 0",
               gnt_o, s_stb_o, err_o, m0_ack_o);
    end
    rst_i = 0; clear_inputs(); step(); rst_i = 1;
  endtask
`endif

  // Model: the bus is either free, owned by a master, or held by it until ack falls.
  task automatic test_random(input int ncyc);
    int phase, own, lastw, wd;
    bit to, ack_v;
    logic [31:0] dat_v, e_adr, e_wdat, e_d0, e_d1;
    logic [1:0]  e_gnt;
    logic [3:0]  e_sel;
    logic        e_stb, e_we, e_a0, e_a1;
    clear_inputs();
    rst_i = 0; step(); rst_i = 1;
    phase = 0; own = 1; lastw = 1; wd = 0;
    for (int c = 0; c < ncyc; c++) begin
      if ($urandom_range(0, 3) == 0) m0_stb_i = ~m0_stb_i;
      if ($urandom_range(0, 3) == 0) m1_stb_i = ~m1_stb_i;
      m0_we_i = $urandom_range(0, 1); m1_we_i = $urandom_range(0, 1);
      m0_adr_i = $urandom; m1_adr_i = $urandom; m0_dat_i = $urandom; m1_dat_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      s_ack_i = ($urandom_range(0, 2) == 0); s_dat_i = $urandom;
      rst_i = ($urandom_range(0, 63) != 0);
      #1;
      to    = TO_EN && phase == 1 && wd == TB_TO;
      ack_v = s_ack_i || to;
      dat_v = to ? 32'hDEADBEEF : s_dat_i;
      e_gnt = 2'b00; e_stb = 0; e_we = 0; e_adr = 0; e_wdat = 0; e_sel = 0;
      e_a0 = 0; e_a1 = 0; e_d0 = 0; e_d1 = 0;
      if (phase != 0) begin
        e_gnt  = (own == 1) ? 2'b10 : 2'b01;
        e_stb  = (phase == 1) && !to;
        e_we   = own ? m1_we_i  : m0_we_i;
        e_adr  = own ? m1_adr_i : m0_adr_i;
        e_wdat = own ? m1_dat_i : m0_dat_i;
        e_sel  = own ? m1_sel_i : m0_sel_i;
        if (own == 1) begin e_a1 = ack_v; e_d1 = dat_v; end
        else begin e_a0 = ack_v; e_d0 = dat_v; end
      end
      checks++;
      if ({gnt_o, s_stb_o, err_o} !== {e_gnt, e_stb, to}) begin
        errors++;
        $display("FAIL rand_ctrl c%0d: got gnt=%b stb=%b err=%b expected %b %b %b",
                 c, gnt_o, s_stb_o, err_o, e_gnt, e_stb, to);
      end
      checks++;
      if ({s_we_o, s_adr_o, s_dat_o, s_sel_o} !== {e_we, e_adr, e_wdat, e_sel}) begin
        errors++;
        $display("FAIL rand_slave c%0d: got %b %h %h %h expected %b %h %h %h",
                 c, s_we_o, s_adr_o, s_dat_o, s_sel_o, e_we, e_adr, e_wdat, e_sel);
      end
      checks++;
      if ({m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o} !== {e_a0, e_d0, e_a1, e_d1}) begin
        errors++;
        $display("FAIL rand_master c%0d: got %b %h %b %h expected %b %h %b %h",
                 c, m0_ack_o, m0_dat_o, m1_ack_o, m1_dat_o, e_a0, e_d0, e_a1, e_d1);
      end
      @(posedge clk);
      if (!rst_i) begin
        phase = 0; lastw = 1; own = 1; wd = 0;
      end else if (phase == 0) begin
        if (m0_stb_i && m1_stb_i) own = 1 - lastw;
        else if (m0_stb_i)        own = 0;
        else if (m1_stb_i)        own = 1;
        if (m0_stb_i || m1_stb_i) begin phase = 1; lastw = own; end
        wd = 0;
      end else if (phase == 1) begin
        if (to) begin phase = 2; wd = 0; end
        else if (!(own ? m1_stb_i : m0_stb_i)) begin phase = s_ack_i ? 2 : 0; wd = 0; end
        else if (s_ack_i) wd = 0;
        else wd++;
      end else if (!s_ack_i) begin
        phase = 0;
      end
      #1;
    end
    rst_i = 1;
    clear_inputs();
    rst_i = 0; step(); rst_i = 1;
  endtask

  initial begin
    clear_inputs();
    rst_i = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_late_ack();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hang();
`endif
    test_random(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU's Wishbone-style bus (stb/we/adr/dat/sel/ack).
- Shares the single memory/peripheral bus between master 0 (CPU core) and master 1 (DMA or debug port).
- Round-robin arbitration. Grant is held for the whole handshake, which ends when the master drops stb and the slave drops ack.
- Sits between the CPU top-level bus ports and the memory/peripheral decoder.

Parameters:
- TIMEOUT, 255: slave-ack watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.
- TO_W, 8: width of the watchdog counter. Must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- m0_stb_i, m0_we_i  in  1 each  master 0 strobe / write enable.
- m0_adr_i, m0_dat_i  in  32 each  master 0 address / write data.
- m0_sel_i  in  4  master 0 byte selects.
- m0_ack_o  out  1  ack to master 0.
- m0_dat_o  out  32  read data to master 0.
- m1_*: same set as m0_*, for master 1.
- s_stb_o, s_we_o  out  1 each  slave strobe / write enable.
- s_adr_o, s_dat_o  out  32 each  slave address / write data.
- s_sel_o  out  4  slave byte selects.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  2  one-hot current grant; 00 = idle.
- err_o  out  1  one-cycle pulse on watchdog expiry. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - state=IDLE, gnt_o=00, last=1 (so master 0 wins the first tie), watchdog=0.
  - With gnt_o=00, every output is forced to 0.
- States:
  - IDLE: no grant.
  - GNT0: master 0 owns the bus.
  - GNT1: master 1 owns the bus.
  - RELEASE: wait for ack to drop.
- IDLE transitions:
  - Only m0_stb_i → GNT0. Only m1_stb_i → GNT1.
  - Both asserted → grant the master other than `last`.
  - `last` updates when a grant is issued.
- Arbitration latency: exactly 1 cycle. A request seen in IDLE at edge N gives gnt_o and s_stb_o asserted after edge N.
- GNTx datapath (combinational from the registered grant):
  - s_stb/we/adr/dat/sel = the granted master's signals.
  - mx_ack_o = s_ack_i, mx_dat_o = s_dat_i for the granted master.
  - The non-granted master sees ack=0 and dat=0.
- GNTx exit:
  - Granted mx_stb_i=0 and s_ack_i=0 → IDLE. Both masters are re-arbitrated next cycle.
  - Granted mx_stb_i=0 and s_ack_i=1 → RELEASE.
- RELEASE:
  - s_stb_o=0; ack is still forwarded to the previous owner, which supports the CPU's wait-for-!ack in its LOAD/STORE states.
  - s_ack_i=0 → IDLE.
- Fairness guarantees:
  - A grant is never revoked while the owning master's stb is high.
  - A master that holds stb continuously is never starved: at most one foreign transaction precedes it.
- Simultaneous events:
  - Owner releases in the same cycle the other master requests → pass through IDLE, 1 dead cycle, then grant the other master.
  - The owner re-asserting stb in IDLE competes under round-robin rules, so it loses to a pending request.
- Reset mid-transaction: grant is dropped immediately; s_stb_o=0 on the next cycle whatever the slave ack state.
- Read data width: 32-bit pass-through only. No byte lane steering, which belongs to the slave/decoder.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - The watchdog counts cycles in GNTx with s_stb_o=1 and s_ack_i=0.
  - It clears on ack or on grant change.
  - When it reaches TIMEOUT: synthesize a one-cycle mx_ack_o=1 with mx_dat_o=32'hDEAD_BEEF, pulse err_o=1, force s_stb_o=0, and go to RELEASE.
- When not defined: no counter, err_o=0, and a slave that never acks hangs the granted master forever.

Test Plan:
- Reset: rst_i=0 for 2 cycles with both stb=1 → all outputs 0, gnt_o=00. After release, gnt_o=01 one cycle later.
- Single CPU read: m0 read at adr 0x100, slave acks after 3 cycles with 0x12345678 → m0_ack_o=1, m0_dat_o=0x12345678; m1 sees ack=0; IDLE after ack drops.
- Contention: both stb high in IDLE → gnt 01 then 10 then 01 across three back-to-back transactions (strict alternation).
- Late ack: m1 write to 0x200 with sel=0011, dat=0xABCD; m1 drops stb while s_ack_i is still 1 → RELEASE with s_stb_o=0; m0 granted only after ack falls.
- Reset mid-transaction: rst_i=0 while GNT1 and waiting for ack → s_stb_o=0 next cycle, gnt_o=00.
- ARB_TIMEOUT_EN with TIMEOUT=4 and a silent slave → after 4 cycles, m0_ack_o=1, dat=0xDEADBEEF, err_o pulses for one cycle, bus returns to IDLE.
